// File: rtl/ov7670_pixel_capture_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ov7670_pixel_capture_if : captured-pixel stream (valid/ready)      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface ov7670_pixel_capture_if #(
   parameter int H_PIXELS = 320,
   parameter int V_LINES  = 240
);
   localparam int XW = $clog2(H_PIXELS);
   localparam int YW = $clog2(V_LINES);

   logic [15:0]   pixelData;
   logic          pixelValid;
   logic          pixelReady;
   logic [XW-1:0] pixelX;
   logic [YW-1:0] pixelY;

   modport master (output pixelData, pixelValid, pixelX, pixelY, input pixelReady);
   modport slave  (input pixelData, pixelValid, pixelX, pixelY, output pixelReady);
endinterface
`default_nettype wire

// File: rtl/ov7670_pixel_capture.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ov7670_pixel_capture : OV7670 byte stream -> RGB565 pixels + x/y   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module ov7670_pixel_capture #(
   parameter int H_PIXELS = 320,
   parameter int V_LINES  = 240
) (
   input  wire logic       clk,
   input  wire logic       reset,
   input  wire logic       pclk,
   input  wire logic       href,
   input  wire logic       vsync,
   input  wire logic [7:0] camData,
   ov7670_pixel_capture_if.master pix,
   output logic            frameStart,
   output logic            lineError,
   output logic            overflow
);
   localparam int XW = $clog2(H_PIXELS);
   localparam int YW = $clog2(V_LINES);
   localparam int FW = 16 + XW + YW;
   localparam logic [XW-1:0] COL_LAST  = XW'(H_PIXELS - 1);
   localparam logic [YW-1:0] LINE_LAST = YW'(V_LINES - 1);

   typedef enum logic [1:0] {IDLE, WAIT_LINE, HIGH_BYTE, LOW_BYTE} state_t;

   logic [1:0] pclk_sync, href_sync, vsync_sync;
   logic [7:0] data_s1, data_s2;
   logic       pclk_d, href_d, vsync_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         pclk_sync  <= '0;
         href_sync  <= '0;
         vsync_sync <= '0;
         data_s1    <= '0;
         data_s2    <= '0;
         pclk_d     <= 1'b0;
         href_d     <= 1'b0;
         vsync_d    <= 1'b0;
      end else begin
         pclk_sync  <= {pclk_sync[0], pclk};
         href_sync  <= {href_sync[0], href};
         vsync_sync <= {vsync_sync[0], vsync};
         data_s1    <= camData;
         data_s2    <= data_s1;
         pclk_d     <= pclk_sync[1];
         href_d     <= href_sync[1];
         vsync_d    <= vsync_sync[1];
      end
   end

   logic pclk_rise, href_fall, vsync_rise, href_now;
   assign href_now   = href_sync[1];
   assign pclk_rise  = pclk_sync[1] & ~pclk_d;
   assign href_fall  = ~href_now & href_d;
   assign vsync_rise = vsync_sync[1] & ~vsync_d;

   state_t        state, state_nxt;
   logic [XW-1:0] col, col_nxt;
   logic          col_full, col_full_nxt;  // column has reached H_PIXELS
   logic [YW-1:0] line, line_nxt;
   logic [7:0]    hi_byte, hi_nxt;
   logic          line_err_nxt, frame_start_nxt, push;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         col        <= '0;
         col_full   <= 1'b0;
         line       <= '0;
         hi_byte    <= '0;
         lineError  <= 1'b0;
         frameStart <= 1'b0;
      end else begin
         state      <= state_nxt;
         col        <= col_nxt;
         col_full   <= col_full_nxt;
         line       <= line_nxt;
         hi_byte    <= hi_nxt;
         lineError  <= line_err_nxt;
         frameStart <= frame_start_nxt;
      end
   end

   always_comb begin
      state_nxt       = state;
      col_nxt         = col;
      col_full_nxt    = col_full;
      line_nxt        = line;
      hi_nxt          = hi_byte;
      line_err_nxt    = lineError;
      frame_start_nxt = 1'b0;
      push            = 1'b0;
      if (vsync_rise) begin
         frame_start_nxt = 1'b1;
         col_nxt         = '0;
         col_full_nxt    = 1'b0;
         line_nxt        = '0;
         line_err_nxt    = 1'b0;
         state_nxt       = WAIT_LINE;
      end else begin
         unique case (state)
            IDLE: ;
            WAIT_LINE: begin
               if (href_now) begin
                  col_nxt      = '0;
                  col_full_nxt = 1'b0;
                  state_nxt    = HIGH_BYTE;
               end
            end
            HIGH_BYTE, LOW_BYTE: begin
               if (href_fall) begin
                  if (state == LOW_BYTE || !col_full)
                     line_err_nxt = 1'b1;
                  line_nxt  = (line == LINE_LAST) ? '0 : line + YW'(1);
                  state_nxt = WAIT_LINE;
               end else if (pclk_rise && href_now) begin
                  if (state == HIGH_BYTE) begin
                     hi_nxt    = data_s2;
                     state_nxt = LOW_BYTE;
                  end else begin
                     if (col_full) begin
                        line_err_nxt = 1'b1;
                     end else begin
                        push = 1'b1;
                        if (col == COL_LAST)
                           col_full_nxt = 1'b1;
                        else
                           col_nxt = col + XW'(1);
                     end
                     state_nxt = HIGH_BYTE;
                  end
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Two-entry output FIFO; a full FIFO still accepts a push when it pops.
   logic [FW-1:0] mem [2];
   logic          wr_ptr, rd_ptr;
   logic [1:0]    count;
   logic          pop, full, push_ok;

   assign full    = (count == 2'd2);
   assign pop     = (count != 2'd0) & pix.pixelReady;
   assign push_ok = push & (~full | pop);

   always_ff @(posedge clk) begin
      if (reset) begin
         mem[0]   <= '0;
         mem[1]   <= '0;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         count    <= 2'd0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= {hi_byte, data_s2, col, line};
            wr_ptr      <= ~wr_ptr;
         end
         if (pop)
            rd_ptr <= ~rd_ptr;
         unique case ({push_ok, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
         if (push && full && !pop)
            overflow <= 1'b1;
      end
   end

   assign pix.pixelValid = (count != 2'd0);
   assign {pix.pixelData, pix.pixelX, pix.pixelY} = mem[rd_ptr];
endmodule
`default_nettype wire

// File: tb/tb_ov7670_pixel_capture.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_ov7670_pixel_capture : randomized scoreboard bench              |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_ov7670_pixel_capture;
   localparam int H = 6;
   localparam int V = 3;

   logic       clk, reset, pclk, href, vsync;
   logic [7:0] camData;
   logic       frameStart, lineError, overflow;

   ov7670_pixel_capture_if #(.H_PIXELS(H), .V_LINES(V)) pif ();

   ov7670_pixel_capture #(.H_PIXELS(H), .V_LINES(V)) dut (
      .clk(clk), .reset(reset), .pclk(pclk), .href(href), .vsync(vsync),
      .camData(camData), .pix(pif), .frameStart(frameStart),
      .lineError(lineError), .overflow(overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Behavioural model state
   logic [31:0] exp_q[$];
   bit          armed = 0;
   bit          hold = 0;
   int          held = 0;
   int          exp_line = 0;
   bit          exp_err = 0;
   bit          exp_ovf = 0;
   int          fs_exp = 0;
   int          fs_seen = 0;
   int          valid_cycles = 0;
   int          nb = 0;
   logic [7:0]  lbuf[64];
   logic [31:0] mon_act;
   int          snap;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic outputs_zero(input string tag);
      chk({tag, "_data"},  32'(pif.pixelData), 0);
      chk({tag, "_valid"}, 32'(pif.pixelValid), 0);
      chk({tag, "_x"},     32'(pif.pixelX), 0);
      chk({tag, "_y"},     32'(pif.pixelY), 0);
      chk({tag, "_fs"},    32'(frameStart), 0);
      chk({tag, "_lerr"},  32'(lineError), 0);
      chk({tag, "_ovf"},   32'(overflow), 0);
   endtask

   task automatic vsync_pulse();
      vsync = 1'b1;
      armed = 1;
      exp_line = 0;
      exp_err = 0;
      fs_exp++;
      tick(4);
      vsync = 1'b0;
      tick(4);
   endtask

   task automatic begin_line();
      href = 1'b1;
      nb = 0;
      tick(3);
   endtask

   task automatic send_byte(input logic [7:0] b);
      camData = b;
      tick(3);
      pclk = 1'b1;
      lbuf[nb] = b;
      if (armed && nb % 2 == 1 && nb / 2 < H) begin
         if (!hold) begin
            exp_q.push_back({lbuf[nb-1], b, 8'(nb / 2), 8'(exp_line)});
         end else if (held < 2) begin
            exp_q.push_back({lbuf[nb-1], b, 8'(nb / 2), 8'(exp_line)});
            held++;
         end else begin
            exp_ovf = 1;
         end
      end
      nb++;
      tick(3);
      pclk = 1'b0;
   endtask

   task automatic end_line();
      tick(2);
      href = 1'b0;
      if (armed) begin
         if (nb % 2 == 1 || nb / 2 != H) exp_err = 1;
         exp_line = (exp_line + 1) % V;
      end
      tick(4);
   endtask

   task automatic random_line(input int n);
      begin_line();
      for (int i = 0; i < n; i++) send_byte(8'($urandom));
      end_line();
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
      #2;
      chk(name, exp_q.size(), 0);
   endtask

   // Ready driver: never low for more than 3 consecutive cycles unless held.
   initial begin
      int gap = 0;
      pif.pixelReady = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (hold) begin
            pif.pixelReady = 1'b0;
         end else if (gap > 0) begin
            pif.pixelReady = 1'b0;
            gap--;
         end else begin
            pif.pixelReady = 1'b1;
            gap = $urandom_range(0, 3);
         end
      end
   end

   // Monitor: every presented pixel must match the scoreboard head.
   initial begin
      forever begin
         @(negedge clk);
         if (frameStart) fs_seen++;
         if (pif.pixelValid) begin
            valid_cycles++;
            mon_act = {pif.pixelData, 8'(pif.pixelX), 8'(pif.pixelY)};
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_pixel actual=%0h required=none", mon_act);
            end else if (pif.pixelReady) begin
               chk("pixel", mon_act, exp_q.pop_front());
            end else begin
               chk("held_pixel", mon_act, exp_q[0]);
            end
         end
      end
   end

   initial begin
      reset = 1'b1;
      pclk = 1'b0;
      href = 1'b0;
      vsync = 1'b0;
      camData = 8'h00;
      tick(3);
      outputs_zero("reset");
      reset = 1'b0;
      tick(2);

      // No vsync yet: camera activity must be ignored
      snap = valid_cycles;
      random_line(8);
      tick(10);
      chk("idle_no_pixel", valid_cycles - snap, 0);

      // Two known pixels
      vsync_pulse();
      chk("frame_start_once", fs_seen, fs_exp);
      begin_line();
      send_byte(8'hF8); send_byte(8'h00); send_byte(8'h07); send_byte(8'hE0);
      wait_drain("drain_first");
      chk("first_lerr", 32'(lineError), 0);
      chk("first_ovf", 32'(overflow), 0);
      end_line();
      chk("short_line_lerr", 32'(lineError), 32'(exp_err));

      // Full lines with line-counter wrap
      vsync_pulse();
      chk("vsync_clears_lerr", 32'(lineError), 0);
      for (int l = 0; l <= V; l++) begin
         random_line(2 * H);
         chk("full_line_lerr", 32'(lineError), 32'(exp_err));
      end
      wait_drain("drain_full");

      // Odd byte count line
      random_line(3);
      wait_drain("drain_odd");
      chk("odd_line_lerr", 32'(lineError), 1);
      vsync_pulse();
      chk("odd_vsync_clear", 32'(lineError), 0);

      // Random line lengths, including overlong ones
      for (int k = 0; k < 8; k++) begin
         if ($urandom_range(0, 2) == 0) vsync_pulse();
         random_line($urandom_range(1, 2 * H + 3));
         chk("rand_lerr", 32'(lineError), 32'(exp_err));
      end
      wait_drain("drain_rand");
      chk("rand_ovf", 32'(overflow), 0);
      chk("frame_start_count", fs_seen, fs_exp);

      // Stalled consumer: third pixel is dropped
      hold = 1;
      held = 0;
      tick(2);
      begin_line();
      for (int i = 0; i < 6; i++) send_byte(8'($urandom));
      tick(8);
      chk("stall_ovf", 32'(overflow), 32'(exp_ovf));
      chk("stall_valid", 32'(pif.pixelValid), 1);
      end_line();
      hold = 0;
      wait_drain("drain_stall");
      chk("ovf_sticky", 32'(overflow), 1);

      // Reset after a high byte
      vsync_pulse();
      begin_line();
      send_byte(8'h5A);
      reset = 1'b1;
      tick(1);
      outputs_zero("midreset");
      reset = 1'b0;
      exp_q.delete();
      armed = 0;
      exp_err = 0;
      exp_ovf = 0;
      exp_line = 0;
      snap = valid_cycles;
      for (int i = 0; i < 5; i++) send_byte(8'($urandom));
      end_line();
      tick(10);
      chk("after_reset_no_pixel", valid_cycles - snap, 0);
      chk("after_reset_ovf", 32'(overflow), 0);

      // Capture resumes after vsync
      vsync_pulse();
      random_line(2 * H);
      wait_drain("drain_resume");
      chk("resume_lerr", 32'(lineError), 0);
      chk("final_frame_start_count", fs_seen, fs_exp);
      tick(5);
      chk("final_empty", 32'(pif.pixelValid), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/ov7670_pixel_capture.md
OV7670_PIXEL_CAPTURE -- requirements
Module: ov7670_pixel_capture

Interface
REQ-001 SHALL provide parameter H_PIXELS, default 320, pixels per line.
REQ-002 SHALL provide parameter V_LINES, default 240, lines per frame.
REQ-003 SHALL have port clk  input  1  system clock; sole clock, all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port pclk  input  1  camera pixel clock, asynchronous to clk.
REQ-006 SHALL have port href  input  1  camera line-valid, asynchronous.
REQ-007 SHALL have port vsync  input  1  camera frame sync, asynchronous.
REQ-008 SHALL have port camData  input  8  camera byte bus.
REQ-009 SHALL have port pixelData  output  16  RGB565 pixel, first byte in [15:8].
REQ-010 SHALL have port pixelValid  output  1  pixelData/pixelX/pixelY valid.
REQ-011 SHALL have port pixelReady  input  1  downstream accepts the pixel.
REQ-012 SHALL have port pixelX  output  $clog2(H_PIXELS)  column of the presented pixel.
REQ-013 SHALL have port pixelY  output  $clog2(V_LINES)  line of the presented pixel.
REQ-014 SHALL have port frameStart  output  1  one-cycle pulse per vsync rising edge.
REQ-015 SHALL have port lineError  output  1  sticky malformed-line flag.
REQ-016 SHALL have port overflow  output  1  sticky dropped-pixel flag.

Function
REQ-017 SHALL pass pclk, href, vsync and camData through matching two-stage clk-domain synchronizers; all decisions SHALL use the second stage only.
REQ-018 SHALL detect pclk rise as synced pclk=1 with previous synced pclk=0, and href/vsync edges likewise.
REQ-019 SHALL implement states IDLE, WAIT_LINE, HIGH_BYTE, LOW_BYTE; reset enters IDLE.
REQ-020 On vsync rise in any state: frameStart=1 next cycle, column/line counters=0, partial byte discarded, lineError cleared, state->WAIT_LINE.
REQ-021 IDLE SHALL ignore href and pclk until a vsync rise.
REQ-022 WAIT_LINE: synced href=1 -> HIGH_BYTE, column=0.
REQ-023 HIGH_BYTE: pclk rise with href=1 latches camData as high byte -> LOW_BYTE.
REQ-024 LOW_BYTE: pclk rise with href=1 forms {high, camData}, pushes it with current column/line into the output buffer, column+1 -> HIGH_BYTE.
REQ-025 Pixels beyond column H_PIXELS-1 in a line SHALL be dropped, set lineError, column held.
REQ-026 href fall: if state LOW_BYTE or column != H_PIXELS, set lineError; partial byte discarded; line+1, wrapping V_LINES-1 -> 0; state->WAIT_LINE.
REQ-027 vsync rise and href fall in the same cycle: REQ-020 wins, line counter not incremented.
REQ-028 Output buffer SHALL be a 2-entry FIFO of {pixelData, pixelX, pixelY}; pixelValid = not empty; head entry drives outputs; pop on pixelValid & pixelReady.
REQ-029 Push to full FIFO without simultaneous pop SHALL drop the new pixel and set overflow; push and pop in the same cycle when full SHALL succeed.
REQ-030 Latency: pixelValid high in the cycle after the cycle the completing pclk rise is detected, when FIFO was empty.
REQ-031 Outputs SHALL hold stable while pixelValid=1 and pixelReady=0.
REQ-032 overflow SHALL clear only on reset.

Reset
REQ-033 reset=1 at a clk edge SHALL set state IDLE, empty FIFO, counters 0, synchronizers 0, and all outputs 0 (pixelData, pixelValid, pixelX, pixelY, frameStart, lineError, overflow).
REQ-034 reset mid-line SHALL discard partial and buffered pixels; capture resumes only after the next vsync rise.

Verification
REQ-035 vsync pulse, then href with 4 pclk bytes 0xF8,0x00,0x07,0xE0, pixelReady=1 -> frameStart once; pixels 0xF800 (x0,y0), 0x07E0 (x1,y0); flags 0.
REQ-036 Full line of 2*H_PIXELS bytes then href fall, repeat -> second line pixelY=1, pixelX 0..H_PIXELS-1, lineError=0; after V_LINES lines pixelY wraps to 0.
REQ-037 Line with odd byte count (3 bytes) -> one pixel emitted, lineError=1; next vsync rise clears lineError.
REQ-038 pixelReady=0, 3 complete pixels -> first 2 held in order, third dropped, overflow=1; raise pixelReady -> 2 pixels drain, overflow stays 1.
REQ-039 No vsync after reset, href/pclk toggling -> pixelValid stays 0.
REQ-040 reset asserted after high byte of a pixel -> all outputs 0 next cycle; no pixel emitted until next vsync.
